// File: rtl/instr_mem_fetch_if.sv
// Load and fetch bus of the instruction memory: program-load write port plus
// a valid/ready fetch request/response pair.
interface instr_mem_fetch_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic [ADDR_W:0]   load_count;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_err;

  modport master (
    output load_en, load_addr, load_data, req_valid, req_addr, rsp_ready,
    input  load_err, load_count, req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  load_en, load_addr, load_data, req_valid, req_addr, rsp_ready,
    output load_err, load_count, req_ready, rsp_valid, rsp_instr, rsp_err
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a one-cycle registered fetch port.
// A per-word valid bitmap flags out-of-range and never-written reads.
module instr_mem_fetch #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_mem_fetch_if.slave     bus
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              load_in_range, load_hit;
  logic              req_in_range, fetch_hit, accept;
  logic              rsp_valid_q, rsp_err_q, load_err_q;
  logic [DATA_W-1:0] rsp_instr_q;
  logic [ADDR_W:0]   load_count_q;

  assign load_in_range = {1'b0, bus.load_addr} < DEPTH_L;
  assign load_hit      = bus.load_en && load_in_range;
  assign req_in_range  = {1'b0, bus.req_addr} < DEPTH_L;
  // Range check gates the bitmap lookup so an out-of-range index is never used.
  assign fetch_hit     = req_in_range && valid[bus.req_addr];

  // Loads take priority; no dependence on req_valid keeps this path short.
  assign bus.req_ready = !bus.load_en && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // Storage is deliberately not reset; the bitmap masks stale contents.
  always_ff @(posedge clk) begin
    if (load_hit) mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid        <= '0;
      load_err_q   <= 1'b0;
      load_count_q <= '0;
    end else begin
      load_err_q <= bus.load_en && !load_in_range;
      if (load_hit) begin
        valid[bus.load_addr] <= 1'b1;
        if (load_count_q != CNT_MAX) load_count_q <= load_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_instr_q <= fetch_hit ? mem[bus.req_addr] : '0;
      rsp_err_q   <= !fetch_hit;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_instr  = rsp_instr_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.load_err   = load_err_q;
  assign bus.load_count = load_count_q;
endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, loadable instruction memory with a registered, handshaked fetch port; next generation of the combinational program ROM.
- A program is written through a load port, then fetched by the core front end over a valid/ready request/response pair with one-cycle latency.
- A per-word valid bitmap, cleared on reset, gives defined behaviour for out-of-range and never-written addresses.

Parameters:
- ADDR_W, 5, width of the load and fetch word addresses.
- DATA_W, 32, instruction width.
- DEPTH, 32, number of implemented words; legal range 1 to 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write strobe for program load.
- load_addr  in  ADDR_W  load word address.
- load_data  in  DATA_W  load word data.
- load_err  out  1  registered one-cycle pulse: last load address was >= DEPTH.
- load_count  out  ADDR_W+1  number of accepted in-range load writes, saturating.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted this cycle when high with req_valid.
- req_addr  in  ADDR_W  fetch word address.
- rsp_valid  out  1  fetch response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_err  out  1  response is for an out-of-range or unwritten word.

Behaviour:
- Reset (asynchronous assert, synchronous release): rsp_valid=0, rsp_instr=0, rsp_err=0, load_err=0, load_count=0, valid bitmap all 0. Memory array contents are not reset.
- Load, on each clk edge with load_en=1:
  - If load_addr < DEPTH: mem[load_addr] <= load_data; valid[load_addr] <= 1; load_count increments, saturating at all-ones (2**(ADDR_W+1)-1).
  - If load_addr >= DEPTH: no write; load_err=1 for the next cycle only.
  - Rewriting an address overwrites the word and still increments load_count.
- req_ready is combinational: req_ready = !load_en && (!rsp_valid || rsp_ready). Fetches are blocked during load cycles.
- Fetch accept: req_valid && req_ready at edge N. At edge N+1: rsp_valid=1 and rsp_instr/rsp_err are registered.
  - hit = (req_addr < DEPTH) && valid[req_addr].
  - rsp_instr = hit ? mem[req_addr] : 0.
  - rsp_err = !hit.
  - Latency is exactly 1 cycle.
- Hold: while rsp_valid && !rsp_ready, rsp_instr and rsp_err stay stable and no new request is accepted.
- Response drain: when rsp_valid && rsp_ready and no new request is accepted, rsp_valid clears next cycle. rsp_instr keeps its last value.
- Throughput: with rsp_ready held at 1, one request is accepted per cycle and responses stream back to back.
- Ordering: a load at edge N is visible to a fetch accepted at edge N+1 or later. Load and fetch are never accepted in the same cycle.
- load_en asserted while a response is pending: the pending response is unaffected and still drains normally.
- Reset mid-operation: any pending response is discarded and the bitmap is cleared, so previously loaded words read back with rsp_err=1 until reloaded.
- Combinational outputs: none other than req_ready. No combinational path from req_valid to req_ready.

Test Plan:
- Reset, then fetch addr 3 -> rsp_valid after 1 cycle, rsp_instr=0x00000000, rsp_err=1; load_count=0.
- Load addr 0 = 0xC028000A and addr 5 = 0x9917C000 -> load_count=2. Fetch 0 then 5 back to back with rsp_ready=1 -> responses 0xC028000A then 0x9917C000 on consecutive cycles, rsp_err=0.
- Fetch addr 0 with rsp_ready=0 for 3 cycles -> rsp_valid=1 and rsp_instr=0xC028000A held stable; req_ready=0 throughout. Raise rsp_ready -> the next request is accepted that cycle.
- With DEPTH=24, load addr 30 -> load_err pulses one cycle and load_count is unchanged. Fetch addr 30 -> rsp_instr=0, rsp_err=1.
- Assert load_en with req_valid=1 -> req_ready=0 for every load cycle. Load addr 2 = 0x4A3D9000, then fetch 2 on the next cycle -> 0x4A3D9000.
- Assert rst_n low with a response pending -> rsp_valid drops immediately. After release, fetch 0 -> rsp_err=1.
